serial_sub: RTL

//  Bit-serial unsigned subtractor: computes out = num1 - num2 one bit per clock, LSB first,
//  via a single full-subtractor cell and a borrow flop. Reverse operation of the arithmetic

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_sub_fsub.sv | 16 +
 rtl/serial_sub.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Bit counter must reach WIDTH, so it needs room for WIDTH+1 values.
    function automatic int sub_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sub_fsub.sv
// fsub: combinational single-bit full subtractor (a - b - bin).
module fsub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generated/propagated by this bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, LSB first, behind valid/ready.
// Optional build macro: SERIAL_SUB_SAT_EN (clamp the difference to 0 on borrow).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one difference bit per clock through the fsub cell
// DONE  | result presented with out_valid=1 until out_ready
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] out,
    output logic             bout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int              CNT_W    = sub_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             bout_q, bout_d;

    logic             fs_d;
    logic             fs_bo;
    logic [WIDTH-1:0] res_next;

    fsub u_fsub (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bo)
    );

    // Newest bit enters at the MSB; the low WIDTH-1 bits hold what came before.
    assign res_next = {fs_d, res_q};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand shifting, borrow chain and result capture.
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        borrow_d = borrow_q;
        out_d    = out_q;
        bout_d   = bout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = num1;
                    b_d      = num2;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = res_next[WIDTH-1:1];
                borrow_d = fs_bo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // The result register only ever sees the finished difference.
                    bout_d = fs_bo;
`ifdef SERIAL_SUB_SAT_EN
                    out_d  = fs_bo ? '0 : res_next;
`else
                    out_d  = res_next;
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            out_q    <= '0;
            bout_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            out_q    <= out_d;
            bout_q   <= bout_d;
        end
    end

    assign out  = out_q;
    assign bout = bout_q;

endmodule
